// File: rtl/fsm_rr_arbiter_pkg.sv
// rtl/fsm_rr_arbiter_pkg.sv - shared constants for the round-robin arbiter
// Holds requester count, index width and the state codes reported on status.
package fsm_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int ST_W  = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'b000;
    localparam logic [ST_W-1:0] ST_ARB     = 3'b001;
    localparam logic [ST_W-1:0] ST_GRANT   = 3'b010;
    localparam logic [ST_W-1:0] ST_RELEASE = 3'b011;
    localparam logic [ST_W-1:0] ST_TIMEOUT = 3'b100;

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// rtl/fsm_rr_arbiter_rr_pick.sv - combinational round-robin search
// Ports:
//   req   - request vector
//   ptr   - index of the previous owner; search starts at ptr+1
//   idx   - first requesting index found in order ptr+1 .. ptr+4 (mod N_REQ)
//   valid - at least one request is set
import fsm_rr_arbiter_pkg::*;

module rr_pick (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites
    // the others; offset N_REQ wraps back onto ptr itself.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + i[IDX_W-1:0];
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// rtl/fsm_rr_arbiter.sv - four-way round-robin arbiter with hold-time limit
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   req            - per-requester level request
//   done           - completion pulse, honoured only while granting
//   grant          - one-hot grant, only in GRANT
//   owner          - last/current selected requester
//   busy           - any state other than IDLE
//   timeout_err    - one-cycle pulse when a grant is revoked by hold limit
//   status         - current state code
import fsm_rr_arbiter_pkg::*;

module fsm_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             timeout_err,
    output logic [ST_W-1:0]  status
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [ST_W-1:0]  state, state_next;
    logic [IDX_W-1:0] owner_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [7:0]       hold_cnt, hold_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        hold_next  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (|req) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (!pick_valid) begin
                    state_next = ST_IDLE;
                end else begin
                    owner_next = pick_idx;
                    hold_next  = '0;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // done outranks the hold limit, so a completion on the last
                // allowed cycle is a clean release rather than a timeout.
                if (done || !req[owner]) begin
                    state_next = ST_RELEASE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_TIMEOUT;
                end else begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                ptr_next   = owner;
                state_next = (|req) ? ST_ARB : ST_IDLE;
            end
            ST_TIMEOUT: begin
                ptr_next   = owner;
                state_next = ST_RELEASE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_next;
        end
    end

    // Outputs depend only on registered state and owner.
    always_comb begin
        grant = '0;
        if (state == ST_GRANT) grant[owner] = 1'b1;
    end

    assign busy        = (state == ST_ARB) || (state == ST_GRANT) ||
                         (state == ST_RELEASE) || (state == ST_TIMEOUT);
    assign timeout_err = (state == ST_TIMEOUT);
    assign status      = state;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// tb/tb_fsm_rr_arbiter.sv - self-checking bench for fsm_rr_arbiter
module tb_fsm_rr_arbiter;

    localparam int HOLD = 4;

    localparam int P_IDLE = 0;
    localparam int P_ARB  = 1;
    localparam int P_GRNT = 2;
    localparam int P_REL  = 3;
    localparam int P_TMO  = 4;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout_err;
    logic [2:0] status;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_owner;
    int m_ptr;
    int m_held;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [2:0] status;
        logic [1:0] owner;
        logic       busy;
        logic       terr;
    } vec_t;

    vec_t tbl[16];

    fsm_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err),
        .status      (status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_owner = 0;
        m_ptr   = 3;
        m_held  = 0;
    endtask

    // Reference: phase plus "cycles held" count, search by modular arithmetic.
    task automatic tick();
        int n_phase = m_phase;
        int n_owner = m_owner;
        int n_ptr   = m_ptr;
        int n_held  = m_held;
        case (m_phase)
            P_IDLE: if (req != 0) n_phase = P_ARB;
            P_ARB: begin
                if (req == 0) n_phase = P_IDLE;
                else begin
                    for (int k = 4; k >= 1; k--)
                        if (req[(m_ptr + k) % 4]) n_owner = (m_ptr + k) % 4;
                    n_held  = 1;
                    n_phase = P_GRNT;
                end
            end
            P_GRNT: begin
                if (done || !req[m_owner]) n_phase = P_REL;
                else if (m_held == HOLD) n_phase = P_TMO;
                else n_held = m_held + 1;
            end
            P_REL: begin
                n_ptr   = m_owner;
                n_phase = (req != 0) ? P_ARB : P_IDLE;
            end
            default: begin
                n_ptr   = m_owner;
                n_phase = P_REL;
            end
        endcase
        @(posedge clock);
        m_phase = n_phase;
        m_owner = n_owner;
        m_ptr   = n_ptr;
        m_held  = n_held;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        done    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_model(input string name);
        logic [3:0] eg;
        eg = (m_phase == P_GRNT) ? 4'(1 << m_owner) : 4'b0000;
        chk({name, "_grant"}, int'(grant), int'(eg));
        chk({name, "_owner"}, int'(owner), m_owner);
        chk({name, "_status"}, int'(status), m_phase);
        chk({name, "_busy"}, int'(busy), int'(m_phase != P_IDLE));
        chk({name, "_terr"}, int'(timeout_err), int'(m_phase == P_TMO));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        req     = 4'b0000;
        done    = 1'b0;
        model_reset();

        // Reset state, both during and after reset.
        #2;
        chk("rst_grant", int'(grant), 0);
        chk("rst_status", int'(status), 0);
        do_reset();
        chk("rst_owner", int'(owner), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_terr", int'(timeout_err), 0);

        // done ignored while idle.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idle_done_status", int'(status), 0);

        // Two-edge latency from IDLE to grant.
        req = 4'b0001;
        tick();
        chk("lat_arb", int'(status), 1);
        tick();
        chk("lat_grant", int'(grant), 4'b0001);
        chk("lat_owner", int'(owner), 0);
        chk("lat_status", int'(status), 2);

        // Full rotation with req=1111 and done on each grant.
        tbl[0]  = '{4'b1111, 1'b0, 4'b0000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 3'b010, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 3'b011, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 3'b010, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 3'b011, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 3'b001, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0100, 3'b010, 2'd2, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 3'b011, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 3'b001, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 1'b0, 4'b1000, 3'b010, 2'd3, 1'b1, 1'b0};
        tbl[11] = '{4'b1111, 1'b1, 4'b0000, 3'b011, 2'd3, 1'b1, 1'b0};
        tbl[12] = '{4'b1111, 1'b0, 4'b0000, 3'b001, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{4'b1111, 1'b0, 4'b0001, 3'b010, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 3'b011, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 3'b000, 2'd0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            tick();
            chk($sformatf("tbl%0d_grant", i), int'(grant), int'(tbl[i].grant));
            chk($sformatf("tbl%0d_status", i), int'(status), int'(tbl[i].status));
            chk($sformatf("tbl%0d_owner", i), int'(owner), int'(tbl[i].owner));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_terr", i), int'(timeout_err), int'(tbl[i].terr));
        end
        done = 1'b0;

        // Hold limit: exactly HOLD grant cycles then TIMEOUT, RELEASE, ARB, regrant.
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        n = 0;
        while (grant == 4'b0100 && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_len", n, HOLD);
        chk("tmo_status", int'(status), 4);
        chk("tmo_terr", int'(timeout_err), 1);
        chk("tmo_grant", int'(grant), 0);
        tick();
        chk("tmo_rel_status", int'(status), 3);
        chk("tmo_rel_terr", int'(timeout_err), 0);
        tick();
        chk("tmo_arb_status", int'(status), 1);
        tick();
        chk("tmo_regrant", int'(grant), 4'b0100);

        // done on the last allowed cycle wins over the hold limit.
        repeat (HOLD - 1) tick();
        chk("coinc_still_grant", int'(grant), 4'b0100);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("coinc_status", int'(status), 3);
        chk("coinc_terr", int'(timeout_err), 0);

        // Owner 2 withdraws with 0011 pending: search from 3 wraps to 0.
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        chk("wd_owner2", int'(owner), 2);
        req = 4'b0011;
        tick();
        chk("wd_rel", int'(status), 3);
        chk("wd_rel_grant", int'(grant), 0);
        tick();
        tick();
        chk("wd_regrant", int'(grant), 4'b0001);

        // Asynchronous reset mid-grant, then owner 3 again through the wrap.
        do_reset();
        req = 4'b1000;
        tick();
        tick();
        chk("ar_grant3", int'(grant), 4'b1000);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("ar_grant_drop", int'(grant), 0);
        chk("ar_status", int'(status), 0);
        chk("ar_terr", int'(timeout_err), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        req = 4'b1000;
        tick();
        tick();
        chk("ar_regrant", int'(grant), 4'b1000);
        chk("ar_owner", int'(owner), 3);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
